// File: rtl/pid_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : pid_alu_seq
// Purpose  : Sequential datapath ALU for the PID controller. Performs
//            add/sub with optional x2/x4/x8 pre-scale of src0, signed
//            saturation, an iterative radix-2 signed fixed-point multiply
//            (one bit per cycle, DW cycles) and multiply-accumulate into an
//            internal accumulator. Single-cycle ops complete at the start
//            edge; MUL/MAC use a start/busy/done handshake.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            start_i    - request an operation (accepted when not busy)
//            op_i[2:0]  - 000 ADD, 001 SUB, 010 ADD_SAT, 011 SUB_SAT,
//                         100 MUL, 101 MAC, 110 ACC_ADD, 111 ACC_LD
//            scale_i    - src0 pre-shift for the add path (x1/x2/x4/x8)
//            src1_i     - signed operand A
//            src0_i     - signed operand B
//            acc_clr_i  - synchronous accumulator clear (highest priority)
//            dst_o      - registered result
//            acc_o      - accumulator value
//            busy_o     - multiply in progress
//            done_o     - one-cycle pulse when dst_o is newly valid
//            sat_flag_o - last result was clamped
// Options  : `define PID_ALU_ROUND_EN adds 2^(QF-1) to the full product
//            before the right shift (round half up); default truncates.
// Revision : 1.0 - initial release
// ============================================================================
module pid_alu_seq #(
  parameter int DW    = 16,
  parameter int SATW  = 12,
  parameter int QF    = 12,
  parameter int MSATW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [2:0]    op_i,
  input  logic [1:0]    scale_i,
  input  logic [DW-1:0] src1_i,
  input  logic [DW-1:0] src0_i,
  input  logic          acc_clr_i,
  output logic [DW-1:0] dst_o,
  output logic [DW-1:0] acc_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          sat_flag_o
);

  // Add path is evaluated 4 bits wider than DW so that x8 pre-scale plus
  // the add/sub carry can never overflow before saturation.
  localparam int EW = DW + 4;
  localparam int PW = 2 * DW;
  localparam int MW = PW + 1;
  localparam int CW = $clog2(DW);

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_ADD_SAT = 3'b010;
  localparam logic [2:0] OP_SUB_SAT = 3'b011;
  localparam logic [2:0] OP_ACC_ADD = 3'b110;
  localparam logic [2:0] OP_ACC_LD  = 3'b111;

  localparam logic signed [EW-1:0] ADD_MAX = EW'((1 << (SATW - 1)) - 1);
  localparam logic signed [EW-1:0] ADD_MIN = EW'(-(1 << (SATW - 1)));
  localparam logic signed [MW-1:0] MUL_MAX = MW'((1 << (MSATW - 1)) - 1);
  localparam logic signed [MW-1:0] MUL_MIN = MW'(-(1 << (MSATW - 1)));

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  // Clamp helpers return {clamped_flag, DW-bit sign-extended value}. The
  // clamp bounds fit in DW bits, so the low DW bits are already the
  // correct sign extension of the clamped value.
  function automatic logic [DW:0] clamp_add(input logic signed [EW-1:0] v);
    logic [DW:0] r;
    if (v > ADD_MAX)      r = {1'b1, ADD_MAX[DW-1:0]};
    else if (v < ADD_MIN) r = {1'b1, ADD_MIN[DW-1:0]};
    else                  r = {1'b0, v[DW-1:0]};
    return r;
  endfunction

  function automatic logic [DW:0] clamp_mul(input logic signed [MW-1:0] v);
    logic [DW:0] r;
    if (v > MUL_MAX)      r = {1'b1, MUL_MAX[DW-1:0]};
    else if (v < MUL_MIN) r = {1'b1, MUL_MIN[DW-1:0]};
    else                  r = {1'b0, v[DW-1:0]};
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t               state_q,  state_d;
  logic [DW-1:0]        dst_q,    dst_d;
  logic [DW-1:0]        acc_q,    acc_d;
  logic                 sat_q,    sat_d;
  logic                 done_q,   done_d;
  logic signed [PW-1:0] prod_q,   prod_d;
  logic signed [PW-1:0] mcand_q,  mcand_d;
  logic [DW-1:0]        mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic                 is_mac_q, is_mac_d;

  // --------------------------------------------------------------------------
  // Add path
  // --------------------------------------------------------------------------
  logic signed [EW-1:0] s0_ext;
  logic signed [EW-1:0] s0_sh;
  logic signed [EW-1:0] src1_ext;
  logic signed [EW-1:0] acc_ext;
  logic signed [EW-1:0] addsub_sum;
  logic signed [EW-1:0] accadd_sum;
  logic [DW:0]          addsub_clamp;
  logic [DW:0]          accadd_clamp;

  assign s0_ext       = {{(EW-DW){src0_i[DW-1]}}, src0_i};
  assign src1_ext     = {{(EW-DW){src1_i[DW-1]}}, src1_i};
  assign acc_ext      = {{(EW-DW){acc_q[DW-1]}}, acc_q};
  assign s0_sh        = s0_ext <<< scale_i;
  // op_i[0] selects subtraction for both the wrapping and saturating forms.
  assign addsub_sum   = op_i[0] ? (src1_ext - s0_sh) : (src1_ext + s0_sh);
  assign accadd_sum   = acc_ext + s0_sh;
  assign addsub_clamp = clamp_add(addsub_sum);
  assign accadd_clamp = clamp_add(accadd_sum);

  // --------------------------------------------------------------------------
  // Multiply path: radix-2 shift-add. The multiplicand is shifted left and
  // the multiplier right each cycle. The final bit is the multiplier's sign
  // bit (weight -2^(DW-1)), so the last iteration subtracts; this makes the
  // most-negative operand produce the correct product with no special case.
  // --------------------------------------------------------------------------
  logic signed [PW-1:0] addend;
  logic                 last_iter;
  logic signed [PW-1:0] prod_step;
  logic signed [PW-1:0] prod_rnd;
  logic signed [PW-1:0] prod_shift;
  logic signed [MW-1:0] mac_sum;
  logic [DW:0]          mul_clamp;
  logic [DW:0]          mac_clamp;

  assign addend    = mplier_q[0] ? mcand_q : '0;
  assign last_iter = (cnt_q == CW'(DW - 1));
  assign prod_step = last_iter ? (prod_q - addend) : (prod_q + addend);

`ifdef PID_ALU_ROUND_EN
  localparam logic signed [PW-1:0] RND_HALF = PW'(1 << (QF - 1));
  assign prod_rnd = prod_step + RND_HALF;
`else
  assign prod_rnd = prod_step;
`endif

  // Arithmetic shift: truncation toward -inf.
  assign prod_shift = prod_rnd >>> QF;
  assign mac_sum    = {{(MW-DW){acc_q[DW-1]}}, acc_q} + {prod_shift[PW-1], prod_shift};
  assign mul_clamp  = clamp_mul({prod_shift[PW-1], prod_shift});
  assign mac_clamp  = clamp_mul(mac_sum);

  // --------------------------------------------------------------------------
  // Next-state / datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    acc_d    = acc_q;
    sat_d    = sat_q;
    done_d   = 1'b0;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    is_mac_d = is_mac_q;

    case (state_q)
      // FINISH is the cycle in which done is visible; busy is already low,
      // so a new start is accepted there exactly as in IDLE to allow
      // back-to-back issue.
      S_IDLE, S_FINISH: begin
        state_d = S_IDLE;
        if (start_i) begin
          case (op_i)
            OP_ADD, OP_SUB: begin
              dst_d  = addsub_sum[DW-1:0];
              sat_d  = 1'b0;
              done_d = 1'b1;
            end
            OP_ADD_SAT, OP_SUB_SAT: begin
              {sat_d, dst_d} = addsub_clamp;
              done_d         = 1'b1;
            end
            OP_ACC_ADD: begin
              {sat_d, dst_d} = accadd_clamp;
              acc_d          = accadd_clamp[DW-1:0];
              done_d         = 1'b1;
            end
            OP_ACC_LD: begin
              dst_d  = src0_i;
              acc_d  = src0_i;
              sat_d  = 1'b0;
              done_d = 1'b1;
            end
            default: begin
              // MUL / MAC: latch operands and start iterating.
              state_d  = S_MUL_RUN;
              prod_d   = '0;
              mcand_d  = {{DW{src1_i[DW-1]}}, src1_i};
              mplier_d = src0_i;
              cnt_d    = '0;
              is_mac_d = op_i[0];
            end
          endcase
        end
      end

      S_MUL_RUN: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q <<< 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // The result is registered on the last iteration edge so that dst,
        // sat_flag and acc are valid throughout the FINISH cycle in which
        // done is high.
        if (last_iter) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          if (is_mac_q) begin
            {sat_d, dst_d} = mac_clamp;
            acc_d          = mac_clamp[DW-1:0];
          end else begin
            {sat_d, dst_d} = mul_clamp;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Clear wins over any same-edge accumulator write.
    if (acc_clr_i) acc_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dst_q    <= '0;
      acc_q    <= '0;
      sat_q    <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      is_mac_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dst_q    <= dst_d;
      acc_q    <= acc_d;
      sat_q    <= sat_d;
      done_q   <= done_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      is_mac_q <= is_mac_d;
    end
  end

  assign dst_o      = dst_q;
  assign acc_o      = acc_q;
  assign sat_flag_o = sat_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q == S_MUL_RUN);

endmodule
`default_nettype wire

// File: tb/tb_pid_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pid_alu_seq
// Purpose  : Directed self-checking bench for pid_alu_seq (DW=16, SATW=12,
//            QF=12, MSATW=15) with hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pid_alu_seq;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_ADD_SAT = 3'b010;
  localparam logic [2:0] OP_SUB_SAT = 3'b011;
  localparam logic [2:0] OP_MUL     = 3'b100;
  localparam logic [2:0] OP_MAC     = 3'b101;
  localparam logic [2:0] OP_ACC_ADD = 3'b110;
  localparam logic [2:0] OP_ACC_LD  = 3'b111;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [1:0]  scale_i;
  logic [15:0] src1_i;
  logic [15:0] src0_i;
  logic        acc_clr_i;
  logic [15:0] dst_o;
  logic [15:0] acc_o;
  logic        busy_o;
  logic        done_o;
  logic        sat_flag_o;

  int n_checks = 0;
  int n_fail   = 0;

  pid_alu_seq #(
    .DW   (16),
    .SATW (12),
    .QF   (12),
    .MSATW(15)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .scale_i   (scale_i),
    .src1_i    (src1_i),
    .src0_i    (src0_i),
    .acc_clr_i (acc_clr_i),
    .dst_o     (dst_o),
    .acc_o     (acc_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sat_flag_o(sat_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Single-cycle operation: result and done visible right after the start edge.
  task automatic alu_op(input string tag, input logic [2:0] op, input logic [1:0] sc,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e_dst, input logic e_sat, input logic [15:0] e_acc);
    @(negedge clk);
    start_i = 1'b1; op_i = op; scale_i = sc; src1_i = a; src0_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    check({tag, "/done"}, done_o, 1);
    check({tag, "/dst"},  dst_o, e_dst);
    check({tag, "/sat"},  sat_flag_o, e_sat);
    check({tag, "/acc"},  acc_o, e_acc);
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, done_o, 0);
  endtask

  // MUL/MAC: measures busy length and done latency, optionally re-issues a
  // start (must be ignored) and pulses acc_clr at given cycles after start.
  task automatic mul_op(input string tag, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e_dst, input logic e_sat, input logic [15:0] e_acc,
                        input int restart_at, input int clr_at);
    int cyc;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start_i = 1'b1; op_i = op; scale_i = 2'b00; src1_i = a; src0_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; src1_i = 16'h5555; src0_i = 16'h3333;
    cyc = 1; busy_cnt = 0; seen = 1'b0;
    while (!seen && cyc <= 40) begin
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (busy_o) busy_cnt++;
        start_i   = (cyc == restart_at);
        op_i      = (cyc == restart_at) ? OP_ADD : op;
        acc_clr_i = (cyc == clr_at);
        @(posedge clk); #1;
        cyc++;
      end
    end
    start_i = 1'b0; acc_clr_i = 1'b0;
    check({tag, "/done_cycle"}, cyc, 17);
    check({tag, "/busy_cycles"}, busy_cnt, 16);
    check({tag, "/busy_low"}, busy_o, 0);
    check({tag, "/dst"}, dst_o, e_dst);
    check({tag, "/sat"}, sat_flag_o, e_sat);
    check({tag, "/acc"}, acc_o, e_acc);
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, done_o, 0);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start_i = 1'b0; op_i = OP_ADD; scale_i = 2'b00;
    src1_i = '0; src0_i = '0; acc_clr_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset/dst",  dst_o, 0);
    check("reset/acc",  acc_o, 0);
    check("reset/busy", busy_o, 0);
    check("reset/done", done_o, 0);
    check("reset/sat",  sat_flag_o, 0);
    @(negedge clk); rst = 1'b0;

    // Add path
    alu_op("add_sat_pos", OP_ADD_SAT, 2'b00, 16'h0700, 16'h0200, 16'h07FF, 1'b1, 16'h0000);
    alu_op("add_plain",   OP_ADD,     2'b00, 16'h0700, 16'h0200, 16'h0900, 1'b0, 16'h0000);
    alu_op("sub_x2",      OP_SUB,     2'b01, 16'h0010, 16'h0004, 16'h0008, 1'b0, 16'h0000);
    alu_op("sub_sat_x4",  OP_SUB_SAT, 2'b10, 16'hF900, 16'h0100, 16'hF800, 1'b1, 16'h0000);
    alu_op("add_wrap",    OP_ADD,     2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 16'h0000);
    alu_op("add_sat_x8",  OP_ADD_SAT, 2'b11, 16'h0010, 16'h0020, 16'h0110, 1'b0, 16'h0000);

    // Multiply path
    mul_op("mul_basic",  OP_MUL, 16'h1000, 16'h0800, 16'h0800, 1'b0, 16'h0000, 5, 0);
    mul_op("mul_maxpos", OP_MUL, 16'h7FFF, 16'h7FFF, 16'h3FFF, 1'b1, 16'h0000, 0, 0);
    mul_op("mul_neg",    OP_MUL, 16'h8000, 16'h7FFF, 16'hC000, 1'b1, 16'h0000, 0, 0);
    mul_op("mul_minmin", OP_MUL, 16'h8000, 16'h8000, 16'h3FFF, 1'b1, 16'h0000, 0, 0);
`ifdef PID_ALU_ROUND_EN
    mul_op("mul_round",  OP_MUL, 16'h0001, 16'h0800, 16'h0001, 1'b0, 16'h0000, 0, 0);
    mul_op("mul_negone", OP_MUL, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000, 0, 0);
`else
    mul_op("mul_round",  OP_MUL, 16'h0001, 16'h0800, 16'h0000, 1'b0, 16'h0000, 0, 0);
    mul_op("mul_negone", OP_MUL, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 0, 0);
`endif

    // Accumulator sequence
    alu_op("acc_ld", OP_ACC_LD, 2'b00, 16'h1234, 16'h0100, 16'h0100, 1'b0, 16'h0100);
    mul_op("mac_1",     OP_MAC, 16'h2000, 16'h1000, 16'h2100, 1'b0, 16'h2100, 0, 0);
    mul_op("mac_clr",   OP_MAC, 16'h1000, 16'h0800, 16'h0800, 1'b0, 16'h0800, 0, 6);
    alu_op("acc_add_sat", OP_ACC_ADD, 2'b01, 16'h0000, 16'h0100, 16'h07FF, 1'b1, 16'h07FF);
    alu_op("acc_add",     OP_ACC_ADD, 2'b00, 16'h0000, 16'hFF00, 16'h06FF, 1'b0, 16'h06FF);

    // Idle clear
    @(negedge clk); acc_clr_i = 1'b1;
    @(posedge clk); #1; acc_clr_i = 1'b0;
    check("acc_clr_idle/acc", acc_o, 0);
    check("acc_clr_idle/dst", dst_o, 16'h06FF);

    // Reset during MUL_RUN
    @(negedge clk);
    start_i = 1'b1; op_i = OP_MUL; src1_i = 16'h1000; src0_i = 16'h0800;
    @(posedge clk); #1; start_i = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
    end
    check("rst_mid/busy_before", busy_o, 1);
    rst = 1'b1;
    #1;
    check("rst_mid/busy", busy_o, 0);
    check("rst_mid/dst",  dst_o, 0);
    check("rst_mid/done", done_o, 0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    check("rst_mid/no_done", dones, 0);
    check("rst_mid/dst_after", dst_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
